uart_cmd_controller: RTL and testbench
======================================

UART_CMD_CONTROLLER -- requirements
Module: uart_cmd_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CLKS, default 34800, which is the inter-byte receive timeout in clk cycles.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port rx_valid, input, 1 bit: one-cycle strobe from the UART receiver marking a received byte.
REQ-005 The block SHALL have port rx_data, input, 8 bits: the received byte, valid when rx_valid=1.
REQ-006 The block SHALL have port tx_data, output, 8 bits: the byte presented to the UART transmitter.
REQ-007 The block SHALL have port tx_valid, output, 1 bit: one-cycle strobe that starts transmission of tx_data.
REQ-008 The block SHALL have port tx_done, input, 1 bit: one-cycle strobe from the transmitter marking the byte as finished.
REQ-009 The block SHALL have port reg_wr_en, output, 1 bit: one-cycle register write strobe.
REQ-010 The block SHALL have port reg_rd_en, output, 1 bit: one-cycle register read strobe.
REQ-011 The block SHALL have port reg_addr, output, 8 bits: the register address.
REQ-012 The block SHALL have port reg_wdata, output, 16 bits: the write data.
REQ-013 The block SHALL have port reg_rdata, input, 16 bits: read data, valid one cycle after reg_rd_en.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have port err_count, output, 8 bits: saturating count of frame errors.

Function
REQ-016 Frame format SHALL be: 0xA5, CMD, ADDR, DHI, DLO, CSUM, where CSUM = CMD^ADDR^DHI^DLO.
REQ-017 The FSM SHALL have these states: IDLE, CMD, ADDR, DHI, DLO, CSUM, EXEC, RD_WAIT, TX_LOAD, TX_WAIT.
REQ-018 In IDLE, an rx_valid byte equal to 0xA5 SHALL move the FSM to CMD; any other byte SHALL be ignored silently.
REQ-019 In states CMD through CSUM, each rx_valid SHALL latch the byte and advance one state; after CSUM the FSM SHALL enter EXEC.
REQ-020 In EXEC with a correct checksum and CMD=0x01, the block SHALL assert reg_wr_en for exactly one cycle, with reg_addr=ADDR and reg_wdata={DHI,DLO}, and queue response ACK (0x06).
REQ-021 In EXEC with a correct checksum and CMD=0x02, the block SHALL assert reg_rd_en for one cycle, go to RD_WAIT, capture reg_rdata on the next cycle, and queue response 0x06, rdata[15:8], rdata[7:0].
REQ-022 In EXEC with a bad checksum or an unknown CMD, the block SHALL perform no register access, queue response NAK (0x15), and increment err_count.
REQ-023 In TX_LOAD, the block SHALL drive tx_data and pulse tx_valid for one cycle, then go to TX_WAIT.
REQ-024 In TX_WAIT, tx_done SHALL return the FSM to TX_LOAD if response bytes remain, otherwise to IDLE.
REQ-025 Response latency SHALL be as follows: the first tx_valid occurs 2 cycles after the CSUM byte for a write, and 3 cycles after it for a read.
REQ-026 rx_valid SHALL be ignored in EXEC, RD_WAIT, TX_LOAD and TX_WAIT; those bytes are dropped and not counted.
REQ-027 The timeout counter SHALL clear on every accepted byte and run only in states CMD through CSUM.
REQ-028 When the timeout counter reaches TIMEOUT_CLKS-1, the FSM SHALL return to IDLE with no response and increment err_count.
REQ-029 A byte arriving in the same cycle as the timeout SHALL take priority: it is accepted and the counter clears.
REQ-030 err_count SHALL saturate at 0xFF with no wrap-around.
REQ-031 reg_wr_en and reg_rd_en SHALL never be high in the same cycle, and SHALL each be at most one cycle per frame.

Reset
REQ-032 reset=0 SHALL, asynchronously at any time, force: state=IDLE, tx_valid=0, tx_data=0, reg_wr_en=0, reg_rd_en=0, reg_addr=0, reg_wdata=0, busy=0, err_count=0, timeout counter=0.
REQ-033 Reset mid-frame or mid-transmission SHALL discard the partial frame and queued response; no further tx_valid may occur until a new frame arrives.

Verification
REQ-034 Write frame A5 01 10 12 34 37 -> one reg_wr_en pulse with addr=0x10, wdata=0x1234; tx byte 0x06; busy low after tx_done.
REQ-035 Read frame A5 02 20 00 00 22 with reg_rdata=0xBEEF -> one reg_rd_en pulse with addr=0x20; tx bytes 06, BE, EF in order, each after the previous tx_done.
REQ-036 Bad checksum A5 01 10 12 34 00 -> no reg_wr_en; tx byte 0x15; err_count=1.
REQ-037 Frame A5 01 stalled for TIMEOUT_CLKS cycles -> FSM returns to IDLE, no tx_valid, err_count increments by 1; a following valid frame is processed normally.
REQ-038 Bytes 00 FF A5 01 10 12 34 37 -> leading 00 and FF ignored; write executes as in REQ-034.
REQ-039 Reset asserted during TX_WAIT of a read response -> all outputs at reset values and no remaining response bytes sent; 260 bad frames -> err_count holds at 0xFF.

Source files
------------

// File: rtl/uart_cmd_controller.sv
// UART command controller: parses A5-framed register commands, performs the
// register access and streams an ACK/NAK (plus read data) back to the transmitter.
module uart_cmd_controller #(
    parameter int TIMEOUT_CLKS = 34800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_done,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    input  logic [15:0] reg_rdata,
    output logic        busy,
    output logic [7:0]  err_count
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK       = 8'h06;
    localparam logic [7:0] NAK       = 8'h15;
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;

    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, DHI, DLO, CSUM, EXEC, RD_WAIT, TX_LOAD, TX_WAIT
    } state_t;

    state_t        state;
    logic [TW-1:0] to_cnt;
    logic [7:0]    cmd_q, addr_q, dhi_q, dlo_q, csum_q;
    logic [7:0]    rsp_hi, rsp_lo;
    logic [1:0]    bytes_left;
    logic          csum_ok;

    assign csum_ok = ((cmd_q ^ addr_q ^ dhi_q ^ dlo_q) == csum_q);
    assign busy    = (state != IDLE);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            to_cnt     <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            reg_wr_en  <= 1'b0;
            reg_rd_en  <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            err_count  <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            dhi_q      <= '0;
            dlo_q      <= '0;
            csum_q     <= '0;
            rsp_hi     <= '0;
            rsp_lo     <= '0;
            bytes_left <= '0;
        end else begin
            // NOTE: strobes default low here so every branch yields a single-cycle pulse;
            // non-blocking updates keep all registers sampling the same pre-edge values.
            tx_valid  <= 1'b0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;

            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (rx_valid && rx_data == SYNC_BYTE)
                        state <= CMD;
                end

                CMD, ADDR, DHI, DLO, CSUM: begin
                    // An arriving byte wins over a timeout in the same cycle.
                    if (rx_valid) begin
                        to_cnt <= '0;
                        case (state)
                            CMD:     begin cmd_q  <= rx_data; state <= ADDR; end
                            ADDR:    begin addr_q <= rx_data; state <= DHI;  end
                            DHI:     begin dhi_q  <= rx_data; state <= DLO;  end
                            DLO:     begin dlo_q  <= rx_data; state <= CSUM; end
                            default: begin csum_q <= rx_data; state <= EXEC; end
                        endcase
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt    <= '0;
                        err_count <= sat_inc(err_count);
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                EXEC: begin
                    if (csum_ok && cmd_q == CMD_WR) begin
                        reg_wr_en  <= 1'b1;
                        reg_addr   <= addr_q;
                        reg_wdata  <= {dhi_q, dlo_q};
                        tx_data    <= ACK;
                        tx_valid   <= 1'b1;
                        bytes_left <= 2'd0;
                        state      <= TX_LOAD;
                    end else if (csum_ok && cmd_q == CMD_RD) begin
                        reg_rd_en <= 1'b1;
                        reg_addr  <= addr_q;
                        state     <= RD_WAIT;
                    end else begin
                        tx_data    <= NAK;
                        tx_valid   <= 1'b1;
                        bytes_left <= 2'd0;
                        err_count  <= sat_inc(err_count);
                        state      <= TX_LOAD;
                    end
                end

                RD_WAIT: begin
                    // The ACK leaves now; the captured read data follows it.
                    rsp_hi     <= reg_rdata[15:8];
                    rsp_lo     <= reg_rdata[7:0];
                    bytes_left <= 2'd2;
                    tx_data    <= ACK;
                    tx_valid   <= 1'b1;
                    state      <= TX_LOAD;
                end

                TX_LOAD: state <= TX_WAIT;

                TX_WAIT: begin
                    if (tx_done) begin
                        if (bytes_left != 2'd0) begin
                            tx_data    <= rsp_hi;
                            rsp_hi     <= rsp_lo;
                            bytes_left <= bytes_left - 2'd1;
                            tx_valid   <= 1'b1;
                            state      <= TX_LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Directed bench for uart_cmd_controller: write, read, NAK, timeout, resync,
// reset during transmission and error-counter saturation.
module tb_uart_cmd_controller;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_done = 1'b0;
    logic        reg_wr_en, reg_rd_en;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata = '0;
    logic        busy;
    logic [7:0]  err_count;

    uart_cmd_controller #(.TIMEOUT_CLKS(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_done   (tx_done),
        .reg_wr_en (reg_wr_en),
        .reg_rd_en (reg_rd_en),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_cyc = 0;

    // Observation side: pulse counters, transmitted byte log, transmitter model.
    int         wr_cnt = 0, rd_cnt = 0, both_cnt = 0, tx_n = 0;
    logic [7:0] last_wr_addr = '0, last_rd_addr = '0;
    logic [15:0] last_wdata = '0;
    logic [7:0] tx_log [1024];
    int         tx_cyc [1024];
    int         done_timer = 0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        tx_done = 1'b0;
        if (done_timer != 0) begin
            done_timer = done_timer - 1;
            if (done_timer == 0) tx_done = 1'b1;
        end
        if (reg_wr_en) begin
            wr_cnt       = wr_cnt + 1;
            last_wr_addr = reg_addr;
            last_wdata   = reg_wdata;
        end
        if (reg_rd_en) begin
            rd_cnt       = rd_cnt + 1;
            last_rd_addr = reg_addr;
        end
        if (reg_wr_en && reg_rd_en) both_cnt = both_cnt + 1;
        if (tx_valid) begin
            tx_log[tx_n % 1024] = tx_data;
            tx_cyc[tx_n % 1024] = cyc;
            tx_n       = tx_n + 1;
            done_timer = 3;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; the byte is sampled on the next edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        last_cyc = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send6(input logic [47:0] f);
        for (int i = 0; i < 6; i++) send_byte(f[47-8*i -: 8]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    int w0, r0, t0;

    task automatic snap();
        w0 = wr_cnt;
        r0 = rd_cnt;
        t0 = tx_n;
    endtask

    initial begin
        // Reset state, with live inputs driven while reset is held.
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_wr_en", reg_wr_en, 1'b0);
        check("rst_rd_en", reg_rd_en, 1'b0);
        check("rst_addr", reg_addr, 8'h00);
        check("rst_wdata", reg_wdata, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err_count, 8'h00);
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;

        // Write A5 01 10 12 34 37
        snap();
        send6(48'hA5_01_10_12_34_37);
        wait_idle("wr_idle");
        check("wr_pulses", wr_cnt - w0, 1);
        check("wr_no_rd", rd_cnt - r0, 0);
        check("wr_addr", last_wr_addr, 8'h10);
        check("wr_wdata", last_wdata, 16'h1234);
        check("wr_tx_count", tx_n - t0, 1);
        check("wr_tx_byte", tx_log[t0], 8'h06);
        check("wr_latency", tx_cyc[t0] - last_cyc, 2);

        // Read A5 02 20 00 00 22 with BEEF
        reg_rdata = 16'hBEEF;
        snap();
        send6(48'hA5_02_20_00_00_22);
        wait_idle("rd_idle");
        check("rd_pulses", rd_cnt - r0, 1);
        check("rd_no_wr", wr_cnt - w0, 0);
        check("rd_addr", last_rd_addr, 8'h20);
        check("rd_tx_count", tx_n - t0, 3);
        check("rd_tx0", tx_log[t0], 8'h06);
        check("rd_tx1", tx_log[t0+1], 8'hBE);
        check("rd_tx2", tx_log[t0+2], 8'hEF);
        check("rd_latency", tx_cyc[t0] - last_cyc, 3);
        check("rd_gap1", tx_cyc[t0+1] - tx_cyc[t0], 4);
        check("rd_gap2", tx_cyc[t0+2] - tx_cyc[t0+1], 4);
        reg_rdata = 16'h0000;

        // Bad checksum
        snap();
        send6(48'hA5_01_10_12_34_00);
        wait_idle("bad_idle");
        check("bad_no_wr", wr_cnt - w0, 0);
        check("bad_tx_count", tx_n - t0, 1);
        check("bad_tx_byte", tx_log[t0], 8'h15);
        check("bad_err", err_count, 8'd1);

        // Unknown command with a correct checksum
        snap();
        send6(48'hA5_03_00_00_00_03);
        wait_idle("unk_idle");
        check("unk_no_access", (wr_cnt - w0) + (rd_cnt - r0), 0);
        check("unk_tx_byte", tx_log[t0], 8'h15);
        check("unk_err", err_count, 8'd2);

        // Leading junk then a write
        snap();
        send_byte(8'h00);
        send_byte(8'hFF);
        check("junk_idle", busy, 1'b0);
        send6(48'hA5_01_10_12_34_37);
        wait_idle("junk_wr_idle");
        check("junk_wr_pulses", wr_cnt - w0, 1);
        check("junk_wr_wdata", last_wdata, 16'h1234);
        check("junk_tx_count", tx_n - t0, 1);
        check("junk_err", err_count, 8'd2);

        // Stall after A5 01: still busy one cycle before expiry, idle after it
        snap();
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (TO - 1) @(posedge clk);
        #1;
        check("to_before", busy, 1'b1);
        @(posedge clk);
        #1;
        check("to_after", busy, 1'b0);
        check("to_err", err_count, 8'd3);
        repeat (5) @(posedge clk);
        #1;
        check("to_no_tx", tx_n - t0, 0);
        send6(48'hA5_01_10_12_34_37);
        wait_idle("to_next_idle");
        check("to_next_wr", wr_cnt - w0, 1);

        // A byte landing on the expiry cycle is accepted
        snap();
        send_byte(8'hA5);
        repeat (TO - 1) @(posedge clk);
        #1;
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h37);
        wait_idle("prio_idle");
        check("prio_wr", wr_cnt - w0, 1);
        check("prio_err", err_count, 8'd3);

        // Reset while waiting for tx_done of the read ACK
        reg_rdata = 16'hBEEF;
        snap();
        send6(48'hA5_02_20_00_00_22);
        for (int n = 0; n < 20 && tx_n == t0; n++) begin
            @(posedge clk);
            #1;
        end
        check("mid_ack_seen", tx_n - t0, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_tx_valid", tx_valid, 1'b0);
        check("mid_rst_tx_data", tx_data, 8'h00);
        check("mid_rst_addr", reg_addr, 8'h00);
        check("mid_rst_err", err_count, 8'h00);
        @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("mid_rst_no_more_tx", tx_n - t0, 1);
        reg_rdata = 16'h0000;

        // Error counter saturation
        for (int i = 1; i <= 260; i++) begin
            send6(48'hA5_01_10_12_34_00);
            wait_idle("sat_idle");
            if (i == 254) check("sat_254", err_count, 8'hFE);
            if (i == 255) check("sat_255", err_count, 8'hFF);
        end
        check("sat_260", err_count, 8'hFF);
        check("never_both", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
